// File: rtl/seq_mult_ctrl.sv
// Iterative shift-and-add unsigned multiplier: one shared WIDTH-bit adder is
// stepped WIDTH times per product, under control of a three-state FSM.
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             c_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;

    // Carry is kept as the top bit of the sum so the shifted-in MSB is exact.
    assign sum = {c_reg, a_reg} + {1'b0, (q_reg[0] ? m_reg : '0)};

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would make the shift read already-updated values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            c_reg   <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= m;
                        q_reg <= q;
                        a_reg <= '0;
                        c_reg <= 1'b0;
                        count <= CW'(WIDTH);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // {C,A,Q} >> 1 with zero into C: sum drops into A, its LSB into Q.
                    c_reg <= 1'b0;
                    a_reg <= sum[WIDTH:1];
                    q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product <= {sum, q_reg[WIDTH-1:1]};
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl (WIDTH=4): stimulus pushes expected
// products with their due cycle; a negedge monitor pops on every done pulse.
module tb_seq_mult_ctrl;

    localparam int WIDTH = 4;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 due;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0]   m;
        logic [WIDTH-1:0]   q;
        logic [2*WIDTH-1:0] p;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   m = '0;
    logic [WIDTH-1:0]   q = '0;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .m       (m),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called on the negedge before the accepting edge: done lands WIDTH edges later.
    task automatic push(input logic [2*WIDTH-1:0] p);
        exp_t e;
        e.prod = p;
        e.due  = cyc + WIDTH + 1;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            check("busy_done_exclusive", int'(busy), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", int'(product), int'(e.prod));
                check("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] mv, input logic [WIDTH-1:0] qv,
                          input logic [2*WIDTH-1:0] p, input string name);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        m = mv;
        q = qv;
        push(p);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            start = 1'b0;
            m = WIDTH'($urandom);
            q = WIDTH'($urandom);
            if (busy) busy_cnt++;
        end
        @(negedge clk);
        @(negedge clk);
        check({name, "_busy_cycles"}, busy_cnt, WIDTH);
        check({name, "_idle_after"}, int'({busy, done}), 0);
    endtask

    vec_t b2b[7] = '{
        '{4'd1,  4'd1,  8'd1},
        '{4'd15, 4'd1,  8'd15},
        '{4'd1,  4'd15, 8'd15},
        '{4'd8,  4'd8,  8'd64},
        '{4'd13, 4'd11, 8'd143},
        '{4'd10, 4'd12, 8'd120},
        '{4'd15, 4'd14, 8'd210}
    };

    initial begin
        int saw_done;
        int n;

        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_product", int'(product), 0);
        rst_n = 1'b1;

        run_op(4'd3,  4'd2,  8'd6,   "3x2");
        run_op(4'd15, 4'd15, 8'd225, "15x15");
        run_op(4'd0,  4'd9,  8'd0,   "0x9");
        run_op(4'd9,  4'd0,  8'd0,   "9x0");

        // start held through RUN with changing operands; second op accepted in DONE.
        @(negedge clk);
        start = 1'b1;
        m = 4'd5;
        q = 4'd7;
        push(8'd35);
        repeat (WIDTH) begin
            @(negedge clk);
            m = WIDTH'($urandom);
            q = WIDTH'($urandom);
        end
        @(negedge clk);
        check("held_done_cycle", int'(done), 1);
        m = 4'd2;
        q = 4'd6;
        push(8'd12);
        @(negedge clk);
        start = 1'b0;
        m = 4'd11;
        q = 4'd11;
        wait_done();

        // Back-to-back stream: next operands presented in each DONE cycle.
        @(negedge clk);
        start = 1'b1;
        m = b2b[0].m;
        q = b2b[0].q;
        push(b2b[0].p);
        for (int i = 1; i < 7; i++) begin
            wait_done();
            m = b2b[i].m;
            q = b2b[i].q;
            push(b2b[i].p);
        end
        wait_done();
        start = 1'b0;

        // Reset mid-operation at E2 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1;
        m = 4'd7;
        q = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_product", int'(product), 0);
        saw_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);

        run_op(4'd6, 4'd5, 8'd30, "6x5");

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
